// File: rtl/chrono_core.sv
// -----------------------------------------------------------------------------
// chrono_core -- centisecond stopwatch core with optional lap capture.
//
// Counts MM:SS.cc in BCD at TICK_HZ while running, driven by a single control
// byte from a PIO register. The control byte is registered once and every
// decision is taken from that registered copy.
//
// Build option:
//   CHRONO_LAP_EN  defined   -> lap capture registers are built (ctrl bit2).
//                  undefined -> lap_bcd / lap_valid are tied to 0 and bit2 is
//                               ignored.
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  count rate in Hz (100 = centiseconds); CLK_HZ/TICK_HZ >= 2
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   ctrl       control byte: bit0 run, bit1 clear, bit2 lap, bits 7:3 unused
//   time_bcd   current time {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
//   lap_bcd    last captured lap time, same format as time_bcd
//   lap_valid  lap_bcd holds a capture
//   running    counter is advancing (state RUN)
//   overflow   sticky: time wrapped past 59:59.99
// -----------------------------------------------------------------------------
module chrono_core #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ctrl,
  output logic [23:0] time_bcd,
  output logic [23:0] lap_bcd,
  output logic        lap_valid,
  output logic        running,
  output logic        overflow
);

  localparam int              DIV        = CLK_HZ / TICK_HZ;
  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  // Per-digit terminal values, cs_u in the low nibble.
  localparam logic [23:0]     TIME_MAX   = 24'h595999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Control register. Only the bits this build uses are kept.
  // ---------------------------------------------------------------------------
`ifdef CHRONO_LAP_EN
  logic [2:0] ctrl_q;
  logic       unused_ctrl;
  assign unused_ctrl = ^ctrl[7:3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl[2:0];
  end
`else
  logic [1:0] ctrl_q;
  logic       unused_ctrl;
  assign unused_ctrl = ^ctrl[7:2];

  // NOTE: registers are written with <= so every flop samples the values
  // from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl[1:0];
  end
`endif

  logic run_c;
  logic clear_c;
  assign run_c   = ctrl_q[0];
  assign clear_c = ctrl_q[1];

  // ---------------------------------------------------------------------------
  // BCD increment with per-digit limits; bit 24 is the carry out of min_t,
  // which only happens when stepping from 59:59.99.
  // ---------------------------------------------------------------------------
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (t[i*4 +: 4] == TIME_MAX[i*4 +: 4]) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // ---------------------------------------------------------------------------
  // State, prescaler, time and overflow
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [23:0]     time_q,  time_d;
  logic            ovf_q,   ovf_d;
  logic            tick;
  logic [24:0]     time_inc;

  assign time_inc = bcd_inc(time_q);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    ovf_d   = ovf_q;
    tick    = 1'b0;

    unique case (state_q)
      IDLE:    if (run_c)  state_d = RUN;
      RUN:     if (!run_c) state_d = PAUSE;
      PAUSE:   if (run_c)  state_d = RUN;
      default:             state_d = IDLE;
    endcase

    // The prescaler only advances in RUN; PAUSE keeps the sub-tick phase.
    if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (state_q == IDLE) begin
      presc_d = '0;
    end

    if (tick) begin
      time_d = time_inc[23:0];
      if (time_inc[24]) ovf_d = 1'b1;
    end

    // Clear overrides everything above.
    if (clear_c) begin
      state_d = IDLE;
      presc_d = '0;
      time_d  = '0;
      ovf_d   = 1'b0;
      tick    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      time_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      ovf_q   <= ovf_d;
    end
  end

  assign time_bcd = time_q;
  assign overflow = ovf_q;
  assign running  = (state_q == RUN);

  // ---------------------------------------------------------------------------
  // Lap capture: rising edge of the registered lap bit, outside IDLE. The
  // captured value is time_q, i.e. the time before a same-cycle tick.
  // ---------------------------------------------------------------------------
`ifdef CHRONO_LAP_EN
  logic        lap_prev_q;
  logic [23:0] lap_q, lap_d;
  logic        lap_valid_q, lap_valid_d;
  logic        lap_rise;

  assign lap_rise = ctrl_q[2] & ~lap_prev_q;

  always_comb begin
    lap_d       = lap_q;
    lap_valid_d = lap_valid_q;
    if (clear_c) begin
      lap_d       = '0;
      lap_valid_d = 1'b0;
    end else if (lap_rise && (state_q != IDLE)) begin
      lap_d       = time_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_prev_q  <= 1'b0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      // Tracks the lap bit unconditionally so a level held through clear or
      // IDLE never looks like a fresh edge later.
      lap_prev_q  <= ctrl_q[2];
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_bcd   = lap_q;
  assign lap_valid = lap_valid_q;
`else
  assign lap_bcd   = '0;
  assign lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_chrono_core.sv
// -----------------------------------------------------------------------------
// tb_chrono_core -- directed, self-checking bench for chrono_core with
// CLK_HZ=1000, TICK_HZ=100 (DIV=10).
//
// Expected values are pushed to a scoreboard queue as each step is driven and
// popped by check(), which compares them with the DUT outputs 1 time unit
// after the active clock edge (or mid-cycle for the async reset step).
//
// Timing reference used in the comments: E0 is the edge just before ctrl is
// set to run. ctrl_q sees run at E1, the state is RUN at E2, the prescaler
// counts from E3 and tick n lands on edge E(2 + 10*n).
// -----------------------------------------------------------------------------
module tb_chrono_core;

`ifdef CHRONO_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  ctrl;
  logic [23:0] time_bcd;
  logic [23:0] lap_bcd;
  logic        lap_valid;
  logic        running;
  logic        overflow;

  chrono_core #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (ctrl),
    .time_bcd  (time_bcd),
    .lap_bcd   (lap_bcd),
    .lap_valid (lap_valid),
    .running   (running),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef enum int {S_TIME, S_LAP, S_LV, S_RUN, S_OVF} sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [23:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Independent model: centisecond count -> BCD via div/mod.
  function automatic logic [23:0] to_bcd(input int cs_in);
    int cs, mn, sc, c;
    cs = cs_in % 360000;
    mn = cs / 6000;
    sc = (cs / 100) % 60;
    c  = cs % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10),
            4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [23:0] observe(input sig_e s);
    case (s)
      S_TIME:  return time_bcd;
      S_LAP:   return lap_bcd;
      S_LV:    return {23'd0, lap_valid};
      S_RUN:   return {23'd0, running};
      default: return {23'd0, overflow};
    endcase
  endfunction

  task automatic expect_out(input string tag, input sig_e s, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic [23:0] t,
                            input logic [23:0] lap, input logic lv,
                            input logic run, input logic ovf);
    expect_out({tag, ".time"},      S_TIME, t);
    expect_out({tag, ".lap_bcd"},   S_LAP,  lap);
    expect_out({tag, ".lap_valid"}, S_LV,   {23'd0, lv});
    expect_out({tag, ".running"},   S_RUN,  {23'd0, run});
    expect_out({tag, ".overflow"},  S_OVF,  {23'd0, ovf});
  endtask

  task automatic check();
    exp_t        e;
    logic [23:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctrl  = 8'h00;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    ctrl  = 8'h00;
    cyc(2);
    expect_all("reset", 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    check();
    reset = 1'b0;

    // Lap request in IDLE is ignored; nothing starts without run.
    ctrl = 8'h04;
    cyc(3);
    expect_all("idle_lap", 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    check();

    // ---- Scenario 1: run for 1000 cycles ------------------------------------
    do_reset();
    ctrl = 8'h01;                       // E0
    cyc(1);                             // E1: only ctrl_q has run
    expect_out("s1.running_e1", S_RUN, 24'd0);
    check();
    cyc(1);                             // E2: RUN
    expect_out("s1.running_e2", S_RUN, 24'd1);
    expect_out("s1.time_e2",    S_TIME, to_bcd(0));
    check();
    cyc(9);                             // E11: one edge short of tick 1
    expect_out("s1.time_e11", S_TIME, to_bcd(0));
    check();
    cyc(1);                             // E12: tick 1
    expect_out("s1.time_e12", S_TIME, to_bcd(1));
    check();
    cyc(988);                           // E1000: (1000-2)/10 = 99 ticks
    expect_out("s1.time_e1000", S_TIME, to_bcd((1000 - 2) / 10));
    expect_out("s1.running",    S_RUN, 24'd1);
    check();

    // ---- Scenario 2: pause keeps the prescaler phase ------------------------
    do_reset();
    ctrl = 8'h01;                       // E0
    cyc(452);                           // E452: tick 45
    expect_out("s2.time_45", S_TIME, to_bcd(45));
    check();
    cyc(3);                             // E455, prescaler = 3
    ctrl = 8'h00;                       // PAUSE at E457 with prescaler = 5
    cyc(2);
    expect_out("s2.paused_run",  S_RUN,  24'd0);
    expect_out("s2.paused_time", S_TIME, to_bcd(45));
    check();
    cyc(48);                            // E505
    expect_out("s2.pause_end_time", S_TIME, to_bcd(45));
    check();
    ctrl = 8'h01;                       // RUN again at E507, prescaler 5
    cyc(6);                             // E511: prescaler 9, no tick yet
    expect_out("s2.resume_run",    S_RUN,  24'd1);
    expect_out("s2.pre_tick_time", S_TIME, to_bcd(45));
    check();
    cyc(1);                             // E512: remaining 5 counts elapsed
    expect_out("s2.resumed_tick", S_TIME, to_bcd(46));
    check();

    // ---- Scenario 3: wrap at 59:59.99 --------------------------------------
    do_reset();
    ctrl = 8'h01;
    cyc(13);                            // E13, just after tick 1
    force dut.time_q = 24'h595999;
    release dut.time_q;
    cyc(8);                             // E21: prescaler 9
    expect_out("s3.loaded",     S_TIME, 24'h595999);
    expect_out("s3.ovf_before", S_OVF,  24'd0);
    check();
    cyc(1);                             // E22: tick wraps
    expect_all("s3.wrap", 24'h000000, 24'h0, 1'b0, 1'b1, 1'b1);
    check();
    cyc(10);                            // counting continues, flag sticky
    expect_out("s3.after_wrap", S_TIME, to_bcd(1));
    expect_out("s3.ovf_sticky", S_OVF,  24'd1);
    check();

    // ---- Scenario 5: clear with run and lap, from RUN with overflow ---------
    ctrl = 8'h07;
    cyc(2);                             // ctrl_q at +1, cleared at +2
    expect_all("s5.clear", 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    check();
    cyc(3);
    expect_all("s5.clear_held", 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    check();
    ctrl = 8'h05;                       // release clear, lap held high
    cyc(3);
    expect_out("s5.restart_run", S_RUN, 24'd1);
    expect_out("s5.held_lap_lv", S_LV,  24'd0);
    check();

    // ---- Scenario 4: lap on the same edge as a tick -------------------------
    do_reset();
    ctrl = 8'h01;                       // E0
    cyc(1240);                          // E1240: tick 123 was at E1232
    expect_out("s4.time_123", S_TIME, to_bcd(123));
    check();
    ctrl = 8'h05;                       // ctrl_q lap at E1241, capture at E1242
    cyc(1);
    expect_out("s4.lv_before", S_LV, 24'd0);
    check();
    cyc(1);                             // E1242: tick 124 and capture
    expect_out("s4.time_124",  S_TIME, to_bcd(124));
    expect_out("s4.lap_bcd",   S_LAP,  LAP_EN ? 24'h000123 : 24'h0);
    expect_out("s4.lap_valid", S_LV,   {23'd0, LAP_EN});
    check();
    cyc(20);                            // held lap: no further capture
    expect_out("s4.time_126",     S_TIME, to_bcd(126));
    expect_out("s4.lap_held",     S_LAP,  LAP_EN ? 24'h000123 : 24'h0);
    expect_out("s4.lap_valid_hd", S_LV,   {23'd0, LAP_EN});
    check();

    // ---- Scenario 6: asynchronous reset mid-cycle ---------------------------
    do_reset();
    ctrl = 8'h01;
    cyc(57);                            // tick 5 at E52
    expect_out("s6.time_5",  S_TIME, to_bcd(5));
    expect_out("s6.running", S_RUN,  24'd1);
    check();
    #3;
    reset = 1'b1;                       // 4 units after the edge
    #1;                                 // next edge still 5 units away
    expect_all("s6.async", 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    check();
    reset = 1'b0;                       // ctrl still run: IDLE until ctrl_q has it
    cyc(1);
    expect_out("s6.idle_after", S_RUN, 24'd0);
    check();
    cyc(1);
    expect_out("s6.run_after",  S_RUN, 24'd1);
    check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
